// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types, encodings and stage constants for fft_stage_sequencer.
// Index widths come from INDEX_WIDTH_M / INDEX_WIDTH_N when the integration defines them.
`ifndef INDEX_WIDTH_M
`define INDEX_WIDTH_M 5
`endif
`ifndef INDEX_WIDTH_N
`define INDEX_WIDTH_N 6
`endif

package fft_seq_pkg;
   localparam int MW = `INDEX_WIDTH_M;
   localparam int NW = `INDEX_WIDTH_N;
   localparam int CW = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      C_IDLE  = 3'd0,
      C_LOAD  = 3'd1,
      C_RUN   = 3'd2,
      C_DRAIN = 3'd3,
      C_HOLD  = 3'd4
   } ctrl_e;

   localparam logic [1:0] SEL_31  = 2'd0;
   localparam logic [1:0] SEL_41  = 2'd1;
   localparam logic [1:0] SEL_61  = 2'd2;
   localparam logic [1:0] SEL_BAD = 2'd3;

   localparam logic [NW-1:0] N_31 = NW'(31);
   localparam logic [NW-1:0] N_41 = NW'(41);
   localparam logic [NW-1:0] N_61 = NW'(61);

   // RUN length per [dft_sel][stage]
   localparam logic [CW-1:0] RUN_LEN [0:2][0:2] = '{
      '{5'd15, 5'd10, 5'd6},
      '{5'd8,  5'd10, 5'd10},
      '{5'd20, 5'd15, 5'd12}
   };

   typedef struct packed {
      logic [2:0]    point;
      logic          mode;
      logic [2:0]    factor_idx;
      logic [1:0]    case_41;
      logic [MW-1:0] m1;
      logic [MW-1:0] m2;
      logic [MW-1:0] m1m2;
      logic [MW-1:0] m0m1;
      logic [MW-1:0] m0m2;
      logic [NW-1:0] n0;
      logic [NW-1:0] n1;
      logic [NW-1:0] n2;
      logic [CW-1:0] run_len;
   } stage_cfg_t;

   function automatic stage_cfg_t mk_cfg(input int point, input int mode, input int c41,
                                         input int m1, input int m2, input int m1m2,
                                         input int m0m1, input int m0m2);
      stage_cfg_t c;
      c            = '0;
      c.point      = 3'(point);
      c.mode       = 1'(mode);
      c.case_41    = 2'(c41);
      c.m1         = MW'(m1);
      c.m2         = MW'(m2);
      c.m1m2       = MW'(m1m2);
      c.m0m1       = MW'(m0m1);
      c.m0m2       = MW'(m0m2);
      return c;
   endfunction
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control-side bus of fft_stage_sequencer: start/select in, AGU stage config and status out.
// The stall signal exists only when FFT_SEQ_STALL_EN is defined.
interface fft_seq_if import fft_seq_pkg::*; ();
   logic          start;
   logic [1:0]    dft_sel;
`ifdef FFT_SEQ_STALL_EN
   logic          stall;
`endif
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    stage_idx;
   logic [2:0]    ctrl_sig;
   logic [2:0]    point;
   logic          point_2_mode;
   logic [2:0]    factor_idx;
   logic [1:0]    case_41;
   logic [MW-1:0] M1, M2, M1M2, M0M1, M0M2;
   logic [NW-1:0] N0, N1, N2;

   // No handshake: start is a level sampled in IDLE, done/err are single-cycle pulses.
   modport master (
`ifdef FFT_SEQ_STALL_EN
      output stall,
`endif
      output start, dft_sel,
      input  busy, done, err, stage_idx, ctrl_sig, point, point_2_mode, factor_idx,
             case_41, M1, M2, M1M2, M0M1, M0M2, N0, N1, N2
   );

   modport slave (
`ifdef FFT_SEQ_STALL_EN
      input  stall,
`endif
      input  start, dft_sel,
      output busy, done, err, stage_idx, ctrl_sig, point, point_2_mode, factor_idx,
             case_41, M1, M2, M1M2, M0M1, M0M2, N0, N1, N2
   );
endinterface

// File: rtl/fft_stage_sequencer_cfg_rom.sv
// Combinational stage-config table: (dft_sel, stage_idx) -> AGU configuration and RUN length.
module fft_stage_cfg_rom import fft_seq_pkg::*; (
   input  logic [1:0] dft_sel,
   input  logic [1:0] stage_idx,
   output stage_cfg_t cfg
);
   always_comb begin
      cfg = '0;
      case ({dft_sel, stage_idx})
         4'h0:    cfg = mk_cfg(2, 0, 0, 3, 5, 15, 6, 10);
         4'h1:    cfg = mk_cfg(3, 0, 0, 2, 5, 10, 6, 15);
         4'h2:    cfg = mk_cfg(5, 0, 0, 2, 3, 6, 10, 15);
         4'h4:    cfg = mk_cfg(5, 0, 1, 8, 0, 8, 0, 5);
         4'h5:    cfg = mk_cfg(4, 0, 2, 2, 5, 5, 8, 0);
         4'h6:    cfg = mk_cfg(2, 1, 2, 4, 5, 5, 8, 0);
         4'h8:    cfg = mk_cfg(3, 0, 0, 4, 5, 20, 12, 15);
         4'h9:    cfg = mk_cfg(4, 0, 0, 3, 5, 15, 12, 20);
         4'hA:    cfg = mk_cfg(5, 0, 0, 3, 4, 12, 15, 20);
         default: cfg = '0;
      endcase
      if (dft_sel != SEL_BAD && stage_idx != 2'd3) begin
         cfg.factor_idx = 3'(dft_sel);
         cfg.run_len    = RUN_LEN[dft_sel][stage_idx];
         case (dft_sel)
            SEL_31:  {cfg.n0, cfg.n1, cfg.n2} = {N_31, N_41, N_61};
            SEL_41:  {cfg.n0, cfg.n1, cfg.n2} = {N_41, N_31, N_61};
            default: {cfg.n0, cfg.n1, cfg.n2} = {N_61, N_31, N_41};
         endcase
      end
   end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences the three prime-factor DFT stages through the AGU with LOAD/RUN/DRAIN ctrl_sig phases.
// Optional FFT_SEQ_STALL_EN adds a stall input that freezes sequencing (ctrl_sig=HOLD in RUN).
module fft_stage_sequencer import fft_seq_pkg::*; #(
   parameter int LOAD_CYC  = 1,
   parameter int DRAIN_CYC = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   fft_seq_if.slave bus,
   output state_e state_dbg
);
   localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_CYC - 1);
   localparam logic [CW-1:0] DRAIN_LAST = (DRAIN_CYC > 0) ? CW'(DRAIN_CYC - 1) : '0;

   state_e        state;
   ctrl_e         ctrl_q;
   logic [1:0]    sel_q;
   logic [1:0]    stage_q;
   logic [CW-1:0] cnt;
   logic          busy_q, done_q, err_q;
   stage_cfg_t    cfg_q, rom_cfg;
   logic [1:0]    rom_sel, rom_stage;
   logic          stall_w;
   logic          stage_end;

`ifdef FFT_SEQ_STALL_EN
   assign stall_w = bus.stall;
`else
   assign stall_w = 1'b0;
`endif

   // The ROM always looks up the stage that the next LOAD will use.
   assign rom_sel   = (state == S_IDLE) ? bus.dft_sel : sel_q;
   assign rom_stage = (state == S_IDLE) ? 2'd0 : stage_q + 2'd1;

   fft_stage_cfg_rom u_rom (
      .dft_sel   (rom_sel),
      .stage_idx (rom_stage),
      .cfg       (rom_cfg)
   );

   assign stage_end = (cnt == '0) &&
                      ((state == S_DRAIN) || (state == S_RUN && DRAIN_CYC == 0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ctrl_q  <= C_IDLE;
         sel_q   <= '0;
         stage_q <= '0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cfg_q   <= '0;
      end else if (stall_w) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state == S_RUN) ctrl_q <= C_HOLD;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.dft_sel == SEL_BAD) begin
                     err_q <= 1'b1;
                  end else begin
                     sel_q   <= bus.dft_sel;
                     stage_q <= 2'd0;
                     cfg_q   <= rom_cfg;
                     cnt     <= LOAD_LAST;
                     busy_q  <= 1'b1;
                     ctrl_q  <= C_LOAD;
                     state   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (cnt == '0) begin
                  state  <= S_RUN;
                  ctrl_q <= C_RUN;
                  cnt    <= cfg_q.run_len - CW'(1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_RUN: begin
               ctrl_q <= C_RUN;
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (DRAIN_CYC > 0) begin
                  state  <= S_DRAIN;
                  ctrl_q <= C_DRAIN;
                  cnt    <= DRAIN_LAST;
               end
            end
            S_DRAIN: begin
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            default: begin
               state  <= S_IDLE;
               ctrl_q <= C_IDLE;
            end
         endcase
         // Stage completion overrides the per-state updates above.
         if (stage_end) begin
            if (stage_q == 2'd2) begin
               state  <= S_DONE;
               ctrl_q <= C_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               stage_q <= stage_q + 2'd1;
               cfg_q   <= rom_cfg;
               cnt     <= LOAD_LAST;
               ctrl_q  <= C_LOAD;
               state   <= S_LOAD;
            end
         end
      end
   end

   assign state_dbg        = state;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.stage_idx    = stage_q;
   assign bus.ctrl_sig     = ctrl_q;
   assign bus.point        = cfg_q.point;
   assign bus.point_2_mode = cfg_q.mode;
   assign bus.factor_idx   = cfg_q.factor_idx;
   assign bus.case_41      = cfg_q.case_41;
   assign bus.M1           = cfg_q.m1;
   assign bus.M2           = cfg_q.m2;
   assign bus.M1M2         = cfg_q.m1m2;
   assign bus.M0M1         = cfg_q.m0m1;
   assign bus.M0M2         = cfg_q.m0m2;
   assign bus.N0           = cfg_q.n0;
   assign bus.N1           = cfg_q.n1;
   assign bus.N2           = cfg_q.n2;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: directed sequences, expected events queued by the driver,
// popped and compared by a negedge monitor.
module tb_fft_stage_sequencer;
   import fft_seq_pkg::*;

   localparam int W = 2 + 2 + 3 + 1 + 3 + 2 + 5*MW + 3*NW + 8;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_e state_dbg;

   always #5 clk = ~clk;

   fft_seq_if bus();

   fft_stage_sequencer #(.LOAD_CYC(1), .DRAIN_CYC(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- record packing ----------------
   function automatic logic [W-1:0] rec_load(input logic [1:0] stage, input logic [2:0] point,
         input logic mode, input logic [1:0] c41, input logic [MW-1:0] m1, input logic [MW-1:0] m2,
         input logic [MW-1:0] m1m2, input logic [MW-1:0] m0m1, input logic [MW-1:0] m0m2,
         input logic [2:0] fidx, input logic [NW-1:0] n0, input logic [NW-1:0] n1,
         input logic [NW-1:0] n2, input logic [7:0] off);
      return {2'd1, stage, point, mode, fidx, c41, m1, m2, m1m2, m0m1, m0m2, n0, n1, n2, off};
   endfunction

   function automatic logic [W-1:0] rec_run(input logic [1:0] stage, input logic [7:0] run,
                                            input logic [7:0] hold);
      return {2'd2, stage, run, hold, {(W-20){1'b0}}};
   endfunction

   function automatic logic [W-1:0] rec_done(input logic [7:0] off, input logic busy);
      return {2'd3, off, busy, {(W-11){1'b0}}};
   endfunction

   function automatic logic [W-1:0] rec_err(input logic [2:0] ctrl, input logic busy);
      return {2'd0, ctrl, busy, {(W-6){1'b0}}};
   endfunction

   function automatic logic [W+4:0] out_word();
      return {bus.busy, bus.done, bus.err, bus.stage_idx, bus.ctrl_sig, bus.point,
              bus.point_2_mode, bus.factor_idx, bus.case_41, bus.M1, bus.M2, bus.M1M2,
              bus.M0M1, bus.M0M2, bus.N0, bus.N1, bus.N2, 8'd0};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   task automatic check_rec(input string name, input logic [W-1:0] act);
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got %h, none expected", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, e);
         end
      end
   endtask

   logic [2:0] prev_ctrl = 3'd0;
   int run_cnt = 0;
   int hold_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ctrl = 3'd0;
         run_cnt   = 0;
         hold_cnt  = 0;
      end else begin
         if (bus.ctrl_sig == C_LOAD && prev_ctrl != C_LOAD)
            check_rec("load", rec_load(bus.stage_idx, bus.point, bus.point_2_mode, bus.case_41,
                      bus.M1, bus.M2, bus.M1M2, bus.M0M1, bus.M0M2, bus.factor_idx,
                      bus.N0, bus.N1, bus.N2, 8'(cyc - start_cyc)));
         if (bus.ctrl_sig == C_RUN) run_cnt++;
         else if (bus.ctrl_sig == C_HOLD) hold_cnt++;
         else if (prev_ctrl == C_RUN || prev_ctrl == C_HOLD) begin
            check_rec("run", rec_run(bus.stage_idx, 8'(run_cnt), 8'(hold_cnt)));
            run_cnt  = 0;
            hold_cnt = 0;
         end
         if (bus.done) begin
            done_seen++;
            check_rec("done", rec_done(8'(cyc - start_cyc), bus.busy));
         end
         if (bus.err) check_rec("err", rec_err(bus.ctrl_sig, bus.busy));
         prev_ctrl = bus.ctrl_sig;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] sel);
      bus.dft_sel = sel;
      bus.start   = 1'b1;
      start_cyc   = cyc;
      tick();
      bus.start   = 1'b0;
   endtask

   task automatic exp_stage(input int stage, input int point, input int mode, input int c41,
         input int m1, input int m2, input int m1m2, input int m0m1, input int m0m2,
         input int fidx, input int n0, input int n1, input int n2, input int off,
         input int run, input int hold);
      exp_q.push_back(rec_load(2'(stage), 3'(point), 1'(mode), 2'(c41), MW'(m1), MW'(m2),
                      MW'(m1m2), MW'(m0m1), MW'(m0m2), 3'(fidx), NW'(n0), NW'(n1), NW'(n2),
                      8'(off)));
      exp_q.push_back(rec_run(2'(stage), 8'(run), 8'(hold)));
   endtask

   task automatic exp_61();
      exp_stage(0, 3, 0, 0, 4, 5, 20, 12, 15, 2, 61, 31, 41, 1, 20, 0);
      exp_stage(1, 4, 0, 0, 3, 5, 15, 12, 20, 2, 61, 31, 41, 26, 15, 0);
      exp_stage(2, 5, 0, 0, 3, 4, 12, 15, 20, 2, 61, 31, 41, 46, 12, 0);
      exp_q.push_back(rec_done(8'd63, 1'b0));
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      int n;
      d0 = done_seen;
      n  = 0;
      while (done_seen == d0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL %s: no done within %0d cycles", name, budget);
      end
   endtask

   task automatic check_idle_zero(input string name);
      checks++;
      if (out_word() !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h required all zero", name, out_word());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start   = 1'b0;
      bus.dft_sel = 2'd0;
`ifdef FFT_SEQ_STALL_EN
      bus.stall   = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) tick();
      check_idle_zero("reset_state");
      rst_n = 1'b1;
      tick();
      check_idle_zero("idle_after_reset");

      // 31-point sequence
      exp_stage(0, 2, 0, 0, 3, 5, 15, 6, 10, 0, 31, 41, 61, 1, 15, 0);
      exp_stage(1, 3, 0, 0, 2, 5, 10, 6, 15, 0, 31, 41, 61, 21, 10, 0);
      exp_stage(2, 5, 0, 0, 2, 3, 6, 10, 15, 0, 31, 41, 61, 36, 6, 0);
      exp_q.push_back(rec_done(8'd47, 1'b0));
      pulse_start(SEL_31);
      wait_done("done_31", 100);
      repeat (3) tick();

      // 41-point sequence with special cases
      exp_stage(0, 5, 0, 1, 8, 0, 8, 0, 5, 1, 41, 31, 61, 1, 8, 0);
      exp_stage(1, 4, 0, 2, 2, 5, 5, 8, 0, 1, 41, 31, 61, 14, 10, 0);
      exp_stage(2, 2, 1, 2, 4, 5, 5, 8, 0, 1, 41, 31, 61, 29, 10, 0);
      exp_q.push_back(rec_done(8'd44, 1'b0));
      pulse_start(SEL_41);
      wait_done("done_41", 100);
      repeat (3) tick();

      // 61-point: start re-pulsed while busy, dft_sel changed mid-run
      exp_61();
      pulse_start(SEL_61);
      repeat (8) tick();
      bus.dft_sel = SEL_31;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      wait_done("done_61", 100);
      repeat (10) tick();

      // illegal select
      exp_q.push_back(rec_err(3'd0, 1'b0));
      pulse_start(SEL_BAD);
      repeat (4) begin
         checks++;
         if (bus.busy !== 1'b0 || bus.ctrl_sig !== 3'd0) begin
            errors++;
            $display("FAIL illegal_idle: busy=%b ctrl=%0d required busy=0 ctrl=0", bus.busy, bus.ctrl_sig);
         end
         tick();
      end

      // reset during stage 1 RUN of 61-point, then a full rerun
      exp_stage(0, 3, 0, 0, 4, 5, 20, 12, 15, 2, 61, 31, 41, 1, 20, 0);
      exp_q.push_back(rec_load(2'd1, 3'd4, 1'b0, 2'd0, MW'(3), MW'(5), MW'(15), MW'(12),
                      MW'(20), 3'd2, NW'(61), NW'(31), NW'(41), 8'd26));
      pulse_start(SEL_61);
      begin
         int n;
         n = 0;
         while (!(bus.ctrl_sig == C_RUN && bus.stage_idx == 2'd1) && n < 100) begin
            tick();
            n++;
         end
         checks++;
         if (n >= 100) begin
            errors++;
            $display("FAIL reach_stage1_run: ctrl=%0d stage=%0d not reached", bus.ctrl_sig, bus.stage_idx);
         end
      end
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check_idle_zero("mid_run_reset");
      tick();
      rst_n = 1'b1;
      tick();
      exp_61();
      pulse_start(SEL_61);
      wait_done("done_61_after_reset", 100);
      repeat (3) tick();

`ifdef FFT_SEQ_STALL_EN
      // 31-point with a 5-cycle stall inside stage 0 RUN
      exp_stage(0, 2, 0, 0, 3, 5, 15, 6, 10, 0, 31, 41, 61, 1, 15, 5);
      exp_stage(1, 3, 0, 0, 2, 5, 10, 6, 15, 0, 31, 41, 61, 26, 10, 0);
      exp_stage(2, 5, 0, 0, 2, 3, 6, 10, 15, 0, 31, 41, 61, 41, 6, 0);
      exp_q.push_back(rec_done(8'd52, 1'b0));
      pulse_start(SEL_31);
      repeat (4) tick();
      bus.stall = 1'b1;
      repeat (5) tick();
      bus.stall = 1'b0;
      wait_done("done_31_stall", 100);
      repeat (3) tick();
`endif

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
